jtag_host_driver: RTL and testbench

Synthesizable JTAG host (TAP master) that drives the SoC's jtag_TCK/jtag_TMS/jtag_TDI and samples jtag_TDO. It converts simple scan commands (TAP reset, IR scan, DR scan, idle clocks) into bit-accurate TCK/TMS/TDI sequences and returns the captured TDO bits. It replaces the external VPI host in self-contained simulation and lets the bench exercise the debug module through the SoC's JTAG interface.

---
 rtl/jtag_host_driver.sv | 183 ++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG TAP master. Turns scan commands into TCK/TMS/TDI
// sequences and returns the TDO bits captured during the shift cycles.
// Every command starts and ends with the TAP in Run-Test/Idle.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_type              0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks
//   cmd_len               bit count (or idle TCK count) minus 1
//   cmd_data              TDI bits, LSB shifted first
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              captured TDO bits, bit i = i-th shifted bit
//   busy                  command running or response pending
//   tck_o, tms_o, tdi_o   JTAG outputs to the SoC
//   tdo_i                 JTAG TDO from the SoC
module jtag_host_driver #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  // Per-TCK-cycle drive: TMS value, whether the cycle shifts, and its bit index.
  typedef struct packed {
    logic       tms;
    logic       shift;
    logic [4:0] idx;
  } cyc_t;

  // Total TCK cycles of a command.
  function automatic logic [5:0] ntck_f(input logic [1:0] typ, input logic [4:0] len);
    logic [5:0] n;
    n = {1'b0, len} + 6'd1;
    case (typ)
      2'd0:    ntck_f = 6'd6;
      2'd1:    ntck_f = n + 6'd6;
      2'd2:    ntck_f = n + 6'd5;
      default: ntck_f = n;
    endcase
  endfunction

  // Decodes TCK cycle k of a command. IR scans walk Idle->SelDR->SelIR->CapIR
  // (4 cycles before the first shift), DR scans Idle->SelDR->CapDR (3 cycles).
  // The last shift leaves via Exit1, then Update and back to Idle.
  function automatic cyc_t cyc_f(input logic [1:0] typ, input logic [4:0] len,
                                 input logic [5:0] k);
    cyc_t       c;
    logic [5:0] n;
    logic [5:0] pre;
    logic [5:0] rel;
    c   = '0;
    n   = {1'b0, len} + 6'd1;
    pre = (typ == 2'd1) ? 6'd4 : 6'd3;
    rel = k - pre;
    case (typ)
      2'd0: c.tms = (k < 6'd5);
      2'd1, 2'd2: begin
        if (k < pre) begin
          c.tms = (typ == 2'd1) ? (k < 6'd2) : (k == 6'd0);
        end else if (rel < n) begin
          c.shift = 1'b1;
          c.idx   = rel[4:0];
          c.tms   = (rel == n - 6'd1);
        end else begin
          c.tms = (rel == n);
        end
      end
      default: c.tms = 1'b0;
    endcase
    return c;
  endfunction

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         tck_cnt;
  logic [1:0]         type_q;
  logic [4:0]         len_q;
  logic [DATA_W-1:0]  data_q;

  cyc_t acc_c;
  cyc_t cur_c;
  cyc_t nxt_c;
  logic last_cyc;

  assign acc_c    = cyc_f(cmd_type, cmd_len, 6'd0);
  assign cur_c    = cyc_f(type_q, len_q, tck_cnt);
  assign nxt_c    = cyc_f(type_q, len_q, tck_cnt + 6'd1);
  assign last_cyc = (tck_cnt == ntck_f(type_q, len_q) - 6'd1);

  // Command capture
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd_valid) begin
      type_q <= cmd_type;
      len_q  <= cmd_len;
      data_q <= cmd_data;
    end
  end

  // TCK generation, TMS/TDI drive and TDO capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      tck_o     <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
      div_cnt   <= '0;
      tck_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_data  <= '0;
            tck_o     <= 1'b0;
            tms_o     <= acc_c.tms;
            tdi_o     <= acc_c.shift & cmd_data[acc_c.idx];
            div_cnt   <= '0;
            tck_cnt   <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!tck_o) begin
              // Rising edge: TDO has been stable for the whole low phase.
              tck_o <= 1'b1;
              if (cur_c.shift) rsp_data[cur_c.idx] <= tdo_i;
            end else begin
              tck_o <= 1'b0;
              if (last_cyc) begin
                tms_o     <= 1'b0;
                tdi_o     <= 1'b0;
                rsp_valid <= 1'b1;
                state     <= S_RESP;
              end else begin
                tck_cnt <= tck_cnt + 6'd1;
                tms_o   <= nxt_c.tms;
                tdi_o   <= nxt_c.shift & data_q[nxt_c.idx];
              end
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver: directed commands against a behavioural TAP
// with a 5-bit IR (reset value IDCODE=0x01), a 32-bit IDCODE register and a
// one-bit bypass register for every other instruction.
module tb_jtag_host_driver;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 32;
  localparam logic [31:0] IDCODE = 32'h1E200A6D;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_type = 2'd0;
  logic [4:0]        cmd_len = 5'd0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              tck_o;
  logic              tms_o;
  logic              tdi_o;
  logic              tdo_i = 1'b0;

  always #5 clk = ~clk;

  jtag_host_driver #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i)
  );

  // TAP model
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_t;

  tap_t        tap = TLR;
  logic [4:0]  ir = 5'h01;
  logic [4:0]  ir_sr = 5'h00;
  logic [31:0] dr_sr = 32'h0;
  logic        byp = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck_o) begin
    case (tap)
      TLR:    ir <= 5'h01;
      CAP_IR: ir_sr <= 5'h01;
      SH_IR:  ir_sr <= {tdi_o, ir_sr[4:1]};
      UPD_IR: ir <= ir_sr;
      CAP_DR: if (ir == 5'h01) dr_sr <= IDCODE; else byp <= 1'b0;
      SH_DR:  if (ir == 5'h01) dr_sr <= {tdi_o, dr_sr[31:1]}; else byp <= tdi_o;
      default: ;
    endcase
    tap <= tap_next(tap, tms_o);
  end

  always @(negedge tck_o) begin
    if (tap == SH_IR)      tdo_i <= ir_sr[0];
    else if (tap == SH_DR) tdo_i <= (ir == 5'h01) ? dr_sr[0] : byp;
    else                   tdo_i <= 1'b0;
  end

  // Per-TCK log of TMS/TDI as seen at each rising TCK edge
  int          tck_pulses = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] tdi_log = '0;

  always @(posedge tck_o) begin
    if (tck_pulses < 64) begin
      tms_log[tck_pulses] = tms_o;
      tdi_log[tck_pulses] = tdi_o;
    end
    tck_pulses = tck_pulses + 1;
  end

  logic rv_seen = 1'b0;
  always @(posedge clk) if (rsp_valid) rv_seen = 1'b1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] typ, input logic [4:0] len,
                         input logic [31:0] data, output int lat);
    @(negedge clk);
    tck_pulses = 0;
    tms_log    = '0;
    tdi_log    = '0;
    cmd_type   = typ;
    cmd_len    = len;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("accept_ready_busy", {62'd0, cmd_ready, busy}, 64'b01);
    lat = 0;
    while (!rsp_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("ack_valid_busy_ready", {61'd0, rsp_valid, busy, cmd_ready}, 64'b001);
  endtask

  initial begin
    int lat;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tck", tck_o, 0);
    chk("rst_tms", tms_o, 1);
    chk("rst_tdi", tdi_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // TAP reset
    run_cmd(2'd0, 5'd0, 32'h0, lat);
    chk("t0_latency", lat, 24);
    chk("t0_rsp", rsp_data, 0);
    chk("t0_pulses", tck_pulses, 6);
    chk("t0_tms", tms_log, 64'h1F);
    chk("t0_tap_rti", 64'(tap), 64'(RTI));
    ack();

    // IR scan of IDCODE
    run_cmd(2'd1, 5'd4, 32'h01, lat);
    chk("ir1_latency", lat, 44);
    chk("ir1_rsp", rsp_data, 64'h1);
    chk("ir1_pulses", tck_pulses, 11);
    chk("ir1_tms", tms_log, 64'h303);
    chk("ir1_tdi", tdi_log, 64'h10);
    chk("ir1_model_ir", ir, 5'h01);
    chk("ir1_tap_rti", 64'(tap), 64'(RTI));
    ack();

    // 32-bit DR scan reads IDCODE
    run_cmd(2'd2, 5'd31, 32'h0, lat);
    chk("id_latency", lat, 148);
    chk("id_rsp", rsp_data, 64'(IDCODE));
    chk("id_pulses", tck_pulses, 37);
    chk("id_tms", tms_log, 64'hC_0000_0001);
    chk("id_tdi", tdi_log, 0);
    ack();

    // Select bypass
    run_cmd(2'd1, 5'd4, 32'h1F, lat);
    chk("ir2_rsp", rsp_data, 64'h1);
    chk("ir2_model_ir", ir, 5'h1F);
    ack();

    // 8-bit scan through bypass, then hold the response
    run_cmd(2'd2, 5'd7, 32'hA5, lat);
    chk("byp_latency", lat, 52);
    chk("byp_rsp", rsp_data, 64'h4A);
    chk("byp_tms", tms_log, 64'hC01);
    chk("byp_tdi", tdi_log, 64'h528);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold", {rsp_valid, rsp_data, cmd_ready, tck_o}, {1'b1, 32'h4A, 1'b0, 1'b0});
    end
    ack();

    // Idle clocks
    run_cmd(2'd3, 5'd3, 32'hF, lat);
    chk("idle_latency", lat, 16);
    chk("idle_pulses", tck_pulses, 4);
    chk("idle_tms", tms_log, 0);
    chk("idle_tdi", tdi_log, 0);
    chk("idle_rsp", rsp_data, 0);
    chk("idle_tap_rti", 64'(tap), 64'(RTI));
    ack();

    // Reset in TCK cycle 7 of a 32-bit DR scan
    @(negedge clk);
    tck_pulses = 0;
    cmd_type   = 2'd2;
    cmd_len    = 5'd31;
    cmd_data   = 32'hFFFF_FFFF;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (tck_pulses < 8 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reach_cycle7", tck_pulses, 8);
    chk("abort_pre_tdi", tdi_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", {58'd0, tck_o, tms_o, tdi_o, cmd_ready, rsp_valid, busy},
        64'b010100);
    @(negedge clk);
    rst     = 1'b0;
    rv_seen = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_rsp", rv_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
